// File: rtl/feeder_pkg.sv
// Shared types and default servo constants for the feeder dispense sequencer.
package feeder_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_OPENING,
        SEQ_DWELL,
        SEQ_CLOSING,
        SEQ_RELEASE
    } seq_state_e;

    localparam int unsigned DEF_PERIOD         = 20000;
    localparam int unsigned DEF_CLOSED_POS     = 1000;
    localparam int unsigned DEF_OPEN_POS       = 2000;
    localparam int unsigned DEF_STEP           = 10;
    localparam int unsigned DEF_RELEASE_FRAMES = 50;

endpackage

// File: rtl/frame_timer.sv
// Modulo-PERIOD frame counter; tick marks the last cycle of each PWM frame.
module frame_timer
    import feeder_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/feeder_servo_seq.sv
// Feeder servo dispense sequencer driving simplePWM time_work/period.
// Optional SERVO_RELEASE_EN adds a hold-then-de-energize RELEASE phase.
module feeder_servo_seq
    import feeder_pkg::*;
#(
    parameter int unsigned PERIOD         = DEF_PERIOD,
    parameter int unsigned CLOSED_POS     = DEF_CLOSED_POS,
    parameter int unsigned OPEN_POS       = DEF_OPEN_POS,
    parameter int unsigned STEP           = DEF_STEP
`ifdef SERVO_RELEASE_EN
    ,
    parameter int unsigned RELEASE_FRAMES = DEF_RELEASE_FRAMES
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] dwell_frames,
    output logic [31:0] time_work,
    output logic [31:0] period,
    output logic        busy,
    output logic        done
);

    seq_state_e  state, state_next;
    logic [31:0] pos, pos_next;
    logic [15:0] dwell_cnt, dwell_next;
    logic        done_next;
    logic        timer_clr;
    logic        tick;

    frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        dwell_next = dwell_cnt;
        done_next  = 1'b0;
        timer_clr  = 1'b0;

        case (state)
            SEQ_IDLE: begin
                // abort is deliberately ignored here, even alongside start
                if (start) begin
                    state_next = SEQ_OPENING;
                    pos_next   = 32'(CLOSED_POS);
                    dwell_next = dwell_frames;
                    timer_clr  = 1'b1;
                end
            end
            SEQ_OPENING: begin
                if (abort) begin
                    state_next = SEQ_CLOSING;
                end else if (tick) begin
                    // distance-to-target form avoids overflow near OPEN_POS
                    if (32'(OPEN_POS) - pos <= 32'(STEP)) begin
                        pos_next   = 32'(OPEN_POS);
                        state_next = SEQ_DWELL;
                    end else begin
                        pos_next = pos + 32'(STEP);
                    end
                end
            end
            SEQ_DWELL: begin
                if (abort) begin
                    state_next = SEQ_CLOSING;
                end else if (tick) begin
                    if (dwell_cnt == 16'd0) begin
                        state_next = SEQ_CLOSING;
                    end else begin
                        dwell_next = dwell_cnt - 16'd1;
                    end
                end
            end
            SEQ_CLOSING: begin
                if (tick) begin
                    if (pos - 32'(CLOSED_POS) <= 32'(STEP)) begin
                        pos_next = 32'(CLOSED_POS);
`ifdef SERVO_RELEASE_EN
                        state_next = SEQ_RELEASE;
                        dwell_next = 16'd0;
`else
                        state_next = SEQ_IDLE;
                        done_next  = 1'b1;
`endif
                    end else begin
                        pos_next = pos - 32'(STEP);
                    end
                end
            end
`ifdef SERVO_RELEASE_EN
            SEQ_RELEASE: begin
                // dwell_cnt is reused as an up-counter of held frames
                if (tick) begin
                    if (dwell_cnt == 16'(RELEASE_FRAMES - 1)) begin
                        pos_next   = 32'd0;
                        state_next = SEQ_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        dwell_next = dwell_cnt + 16'd1;
                    end
                end
            end
`endif
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEQ_IDLE;
            pos       <= '0;
            dwell_cnt <= '0;
            done      <= 1'b0;
            time_work <= '0;
        end else begin
            state     <= state_next;
            pos       <= pos_next;
            dwell_cnt <= dwell_next;
            done      <= done_next;
            time_work <= pos;
        end
    end

    assign period = 32'(PERIOD);
    assign busy   = (state != SEQ_IDLE);

endmodule

// File: tb/tb_feeder_servo_seq.sv
// Self-checking bench for feeder_servo_seq: frame-plan reference model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_feeder_servo_seq;

    localparam int P = 100;
    localparam int C = 10;
    localparam int O = 50;
    localparam int S = 10;
`ifdef SERVO_RELEASE_EN
    localparam int RF      = 3;
    localparam int REL_CYC = RF * P;
`else
    localparam int REL_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] dwell_frames = '0;
    logic [31:0] time_work, period;
    logic        busy, done;

    feeder_servo_seq #(
        .PERIOD(P), .CLOSED_POS(C), .OPEN_POS(O), .STEP(S)
`ifdef SERVO_RELEASE_EN
        , .RELEASE_FRAMES(RF)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .dwell_frames (dwell_frames),
        .time_work    (time_work),
        .period       (period),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: each accepted start lays out a per-frame plan of pulse
    // widths; frame k begins at the k-th frame boundary after the start edge.
    bit act_m = 1'b0;
    bit done_m = 1'b0;
    int pos_m = 0;
    int tw_m = 0;
    int e_m = 0;
    int t0_m = 0;
    int close_idx_m = 0;
    int plan[$];

    task automatic append_close(input int from);
        int p;
        p = from;
        do begin
            p = (p - C <= S) ? C : p - S;
            plan.push_back(p);
        end while (p != C);
`ifdef SERVO_RELEASE_EN
        for (int i = 0; i < RF - 1; i++) plan.push_back(C);
        plan.push_back(0);
`endif
    endtask

    initial begin
        int dt, kc, p, d;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                act_m = 1'b0; done_m = 1'b0; pos_m = 0; tw_m = 0; e_m = 0;
                plan.delete();
            end else begin
                e_m++;
                tw_m   = pos_m;
                done_m = 1'b0;
                if (!act_m) begin
                    if (start) begin
                        plan.delete();
                        plan.push_back(C);
                        p = C;
                        while (p != O) begin
                            p = (O - p <= S) ? O : p + S;
                            plan.push_back(p);
                        end
                        d = int'(dwell_frames);
                        for (int i = 0; i <= d; i++) plan.push_back(O);
                        close_idx_m = plan.size() - 1;
                        append_close(O);
                        act_m = 1'b1;
                        t0_m  = e_m;
                        pos_m = C;
                    end
                end else begin
                    dt = e_m - t0_m;
                    kc = (dt - 1) / P;
                    if (abort && kc < close_idx_m) begin
                        plan = plan[0:kc];
                        append_close(plan[kc]);
                        close_idx_m = kc;
                    end else if (dt % P == 0) begin
                        pos_m = plan[dt / P];
                        if (dt / P == plan.size() - 1) begin
                            act_m  = 1'b0;
                            done_m = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("time_work", time_work, 32'(tw_m));
        check("period", period, 32'(P));
        check("busy", {31'd0, busy}, {31'd0, act_m});
        check("done", {31'd0, done}, {31'd0, done_m});
    end

    // Collapsed history of time_work values plus done bookkeeping.
    int chg[$];
    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (chg.size() == 0 || chg[chg.size()-1] != int'(time_work))
                chg.push_back(int'(time_work));
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int exp_seq[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d, output int edge_n);
        dwell_frames = 16'(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        edge_n = cyc;
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    task automatic wait_tw(input logic [31:0] v, input int budget, input string name);
        int n = 0;
        while (time_work !== v && n < budget) begin
            step(1);
            n++;
        end
        check({name, " reach"}, time_work, v);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic begin_cycle(input int d, input string name, output int n0);
        done_cnt = 0;
        pulse_start(d, n0);
        step(1);
        check({name, " tw@N+1"}, time_work, 32'(C));
        check({name, " busy@N+1"}, {31'd0, busy}, 32'd1);
        chg.delete();
        chg.push_back(C);
    endtask

    task automatic end_cycle(input string name, input int exp_len, input int n0);
        wait_idle(3000, name);
        step(2);
        check({name, " seq len"}, 32'(chg.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < chg.size(); i++)
            check({name, " seq val"}, 32'(chg[i]), 32'(exp_seq[i]));
        check({name, " done count"}, 32'(done_cnt), 32'd1);
        check({name, " done time"}, 32'(done_cyc - n0), 32'(exp_len));
    endtask

    task automatic set_full_seq();
        exp_seq = '{10, 20, 30, 40, 50, 40, 30, 20, 10};
`ifdef SERVO_RELEASE_EN
        exp_seq.push_back(0);
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1;
        #1 reset = 1'b0;
        step(3);
        reset = 1'b1;

        // Idle after reset with no start.
        step(500);
        check("idle tw", time_work, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle period", period, 32'd100);
        check("idle no done", 32'(done_cnt), 32'd0);

        // Full cycle, dwell 2.
        set_full_seq();
        begin_cycle(2, "full", n0);
        end_cycle("full", 1100 + REL_CYC, n0);

        // Abort during OPENING, 10 cycles after 30 appears.
        exp_seq = '{10, 20, 30, 20, 10};
`ifdef SERVO_RELEASE_EN
        exp_seq.push_back(0);
`endif
        begin_cycle(2, "abort", n0);
        wait_tw(32'(30), 400, "abort");
        step(10);
        pulse_abort();
        end_cycle("abort", 400 + REL_CYC, n0);

        // start in DWELL and abort in CLOSING are ignored.
        set_full_seq();
        begin_cycle(2, "ignore", n0);
        wait_tw(32'(50), 600, "ignore");
        step(150);
        pulse_start(0, n0);
        n0 = n0;
        wait_tw(32'(40), 600, "ignore close");
        step(20);
        pulse_abort();
        wait_idle(3000, "ignore");
        step(2);
        check("ignore seq len", 32'(chg.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < chg.size(); i++)
            check("ignore seq val", 32'(chg[i]), 32'(exp_seq[i]));
        check("ignore done count", 32'(done_cnt), 32'd1);

        // Reset mid-cycle while time_work is 40, then a fresh dwell-0 cycle.
        begin_cycle(0, "rst", n0);
        wait_tw(32'(40), 500, "rst");
        step(5);
        #3 reset = 1'b0;
        #1;
        check("rst tw", time_work, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        step(2);
        reset = 1'b1;
        step(2);
        set_full_seq();
        begin_cycle(0, "fresh", n0);
        end_cycle("fresh", 900 + REL_CYC, n0);

        // Randomized soak against the model.
        for (int i = 0; i < 20000; i++) begin
            start        = ($urandom_range(0, 99) == 0);
            abort        = ($urandom_range(0, 1499) == 0);
            dwell_frames = 16'($urandom_range(0, 3));
            step(1);
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle(3000, "soak");
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
